// File: rtl/i2s_dac_tx_pkg.sv
// Shared I2S definitions for the DAC transmit and ADC capture paths.
// Default sample/slot geometry and word-select encoding.
package i2s_dac_tx_pkg;

  localparam int unsigned I2S_WIDTH     = 24;
  localparam int unsigned I2S_SLOT_BITS = 32;

  typedef enum logic {
    WCLK_LEFT  = 1'b0,
    WCLK_RIGHT = 1'b1
  } wclk_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides dac_clk by BCLK_DIV (50% duty) and flags the
// cycle in which the bclk register falls so the caller can update in lockstep.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic dac_clk,
  input  logic dac_clk_rst,
  output logic i2s_bclk,
  output logic bclk_fall
);

  localparam int unsigned H  = BCLK_DIV / 2;
  localparam int unsigned DW = (H > 1) ? $clog2(H) : 1;

  logic [DW-1:0] div;
  logic          tick;

  assign tick      = (div == DW'(H - 1));
  // Registered outputs elsewhere update on this same edge as bclk goes 1->0.
  assign bclk_fall = tick && i2s_bclk;

  always_ff @(posedge dac_clk) begin
    if (dac_clk_rst) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div      <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: holding register with valid/ready intake, frame
// position counter and MSB-first stereo shift register driving one data line.
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int unsigned _WIDTH    = I2S_WIDTH,
  parameter int unsigned SLOT_BITS = I2S_SLOT_BITS,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic              dac_clk,
  input  logic              dac_clk_rst,
  input  logic [_WIDTH-1:0] in_dataL,
  input  logic [_WIDTH-1:0] in_dataR,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              i2s_bclk,
  output logic              i2s_wclk,
  output logic              i2s_dout,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned PW         = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] P_LAST   = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] P_SLOT   = PW'(SLOT_BITS);
  localparam logic [PW-1:0] P_L_LSB  = PW'(_WIDTH);
  localparam logic [PW-1:0] P_R_MSB  = PW'(SLOT_BITS + 1);
  localparam logic [PW-1:0] P_R_LSB  = PW'(SLOT_BITS + _WIDTH);

  logic                  fall;
  logic [PW-1:0]         p;
  logic [PW-1:0]         p_nxt;
  logic                  hold_full;
  logic                  hold_full_nxt;
  logic [2*_WIDTH-1:0]   hold;
  logic [2*_WIDTH-1:0]   shreg;
  logic                  accept;
  logic                  load;
  logic                  data_slot;
  wclk_e                 wclk_q;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .dac_clk     (dac_clk),
    .dac_clk_rst (dac_clk_rst),
    .i2s_bclk    (i2s_bclk),
    .bclk_fall   (fall)
  );

  assign i2s_wclk = wclk_q;

  always_comb begin
    accept        = in_valid && in_ready;
    load          = fall && (p == '0);
    // Load looks at the pre-accept holding state; a same-cycle accept refills it.
    hold_full_nxt = hold_full;
    if (load)   hold_full_nxt = 1'b0;
    if (accept) hold_full_nxt = 1'b1;
    data_slot     = ((p != '0) && (p <= P_L_LSB)) || ((p >= P_R_MSB) && (p <= P_R_LSB));
    p_nxt         = (p == P_LAST) ? '0 : p + PW'(1);
  end

  always_ff @(posedge dac_clk) begin
    if (dac_clk_rst) begin
      p           <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      in_ready    <= 1'b0;
      shreg       <= '0;
      wclk_q      <= WCLK_LEFT;
      i2s_dout    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= hold_full_nxt;
      in_ready    <= ~hold_full_nxt;
      if (accept) hold <= {in_dataL, in_dataR};
      if (fall) begin
        p        <= p_nxt;
        wclk_q   <= (p >= P_SLOT) ? WCLK_RIGHT : WCLK_LEFT;
        i2s_dout <= data_slot ? shreg[2*_WIDTH-1] : 1'b0;
        if (load) begin
          shreg       <= hold_full ? hold : '0;
          frame_start <= 1'b1;
          underrun    <= ~hold_full;
        end else if (data_slot) begin
          shreg       <= {shreg[2*_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule
